// File: rtl/audio_pwm_sink.sv
// PWM audio sink: samples enter a small FIFO via valid/ready, one is popped per sample
// period, and its value sets the PWM high time. Optional build macro: AUDIO_PWM_HOLD_LAST_EN.
module audio_pwm_sink #(
  parameter int unsigned DIV_48KHZ  = 259,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter logic [7:0]  MIDSCALE   = 8'h80
) (
  input  logic                          clk,
  input  logic                          rstn,
  input  logic                          en_i,
  input  logic                          sample_valid_i,
  input  logic [7:0]                    sample_data_i,
  output logic                          sample_ready_o,
  input  logic                          underrun_clr_i,
  output logic                          pwm_o,
  output logic                          sample_tick_o,
  output logic                          underrun_o,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level_o
);

  localparam int unsigned CntW = $clog2(DIV_48KHZ + 1);
  localparam int unsigned CmpW = (CntW > 8) ? CntW : 8;
  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam int unsigned LvlW = PtrW + 1;
  localparam logic [CntW-1:0] CntMax = CntW'(DIV_48KHZ);
  localparam logic [LvlW-1:0] LvlFull = LvlW'(FIFO_DEPTH);

  if (DIV_48KHZ < 255) begin : g_div_chk
    $error("audio_pwm_sink: DIV_48KHZ must be >= 255");
  end
  if ((FIFO_DEPTH < 2) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_depth_chk
    $error("audio_pwm_sink: FIFO_DEPTH must be a power of two >= 2");
  end

  logic [CntW-1:0] r_cnt;
  logic [7:0]      r_cur;
  logic [7:0]      r_mem [FIFO_DEPTH];
  logic [PtrW-1:0] r_rd_ptr;
  logic [PtrW-1:0] r_wr_ptr;
  logic [LvlW-1:0] r_level;
  logic            r_pwm;
  logic            r_under;

  logic w_tick;
  logic w_full;
  logic w_empty;
  logic w_push;
  logic w_pop;

  always_comb begin
    w_tick  = en_i & (r_cnt == CntMax);
    w_full  = (r_level == LvlFull);
    w_empty = (r_level == '0);
    // Ready is forced low during reset even though the level is already zero.
    w_push  = sample_valid_i & sample_ready_o;
    w_pop   = w_tick & ~w_empty;
  end

  assign sample_ready_o = rstn & en_i & ~w_full;
  assign sample_tick_o  = w_tick;
  assign pwm_o          = r_pwm;
  assign underrun_o     = r_under;
  assign fifo_level_o   = r_level;

  // Storage is not reset; validity is tracked solely by the level and pointers.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= sample_data_i;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_cnt    <= '0;
      r_cur    <= MIDSCALE;
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_level  <= '0;
      r_pwm    <= 1'b0;
    end else if (!en_i) begin
      r_cnt    <= '0;
      r_cur    <= MIDSCALE;
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_level  <= '0;
      r_pwm    <= 1'b0;
    end else begin
      r_cnt <= w_tick ? '0 : r_cnt + CntW'(1);
      r_pwm <= (CmpW'(r_cnt) < CmpW'(r_cur));
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PtrW'(1);
      end
      if (w_pop) begin
        r_cur    <= r_mem[r_rd_ptr];
        r_rd_ptr <= r_rd_ptr + PtrW'(1);
      end else if (w_tick) begin
`ifdef AUDIO_PWM_HOLD_LAST_EN
        r_cur <= r_cur;
`else
        r_cur <= MIDSCALE;
`endif
      end
      r_level <= r_level + LvlW'(w_push) - LvlW'(w_pop);
    end
  end

  // Sticky flag survives en_i = 0; a new underrun beats a simultaneous clear.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_under <= 1'b0;
    end else if (w_tick && w_empty) begin
      r_under <= 1'b1;
    end else if (underrun_clr_i) begin
      r_under <= 1'b0;
    end
  end

endmodule

// File: tb/tb_audio_pwm_sink.sv
// Randomized bench for audio_pwm_sink: a queue-based reference model predicts each period's
// PWM high time; a monitor measures windows after each tick and pops expectations.
module tb_audio_pwm_sink;

  localparam int unsigned Div   = 259;
  localparam int unsigned Depth = 4;
  localparam int unsigned Per   = Div + 1;
  localparam logic [7:0]  Mid   = 8'h80;

  logic       clk = 1'b0;
  logic       rstn;
  logic       en_i;
  logic       sample_valid_i;
  logic [7:0] sample_data_i;
  logic       sample_ready_o;
  logic       underrun_clr_i;
  logic       pwm_o;
  logic       sample_tick_o;
  logic       underrun_o;
  logic [2:0] fifo_level_o;

  audio_pwm_sink #(
    .DIV_48KHZ (Div),
    .FIFO_DEPTH(Depth),
    .MIDSCALE  (Mid)
  ) dut (
    .clk           (clk),
    .rstn          (rstn),
    .en_i          (en_i),
    .sample_valid_i(sample_valid_i),
    .sample_data_i (sample_data_i),
    .sample_ready_o(sample_ready_o),
    .underrun_clr_i(underrun_clr_i),
    .pwm_o         (pwm_o),
    .sample_tick_o (sample_tick_o),
    .underrun_o    (underrun_o),
    .fifo_level_o  (fifo_level_o)
  );

  always #40 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  // Reference model: the FIFO as a queue, the period as a plain cycle count.
  logic [7:0] m_fifo[$];
  int         m_cnt;
  logic [7:0] m_cur;
  bit         m_under;
  bit         m_prev_en;
  int         exp_q[$];

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      m_cnt = 0;
      m_fifo.delete();
      m_cur = Mid;
      m_under = 0;
      m_prev_en = 0;
      exp_q.delete();
    end else begin
      bit tick;
      bit push;
      bit was_empty;
      m_prev_en = en_i;
      if (!en_i) begin
        m_cnt = 0;
        m_fifo.delete();
        m_cur = Mid;
        if (underrun_clr_i) m_under = 0;
      end else begin
        tick = (m_cnt == Div);
        push = sample_valid_i && (m_fifo.size() < Depth);
        was_empty = (m_fifo.size() == 0);
        if (tick) begin
          if (!was_empty) begin
            m_cur = m_fifo.pop_front();
          end else begin
            m_under = 1;
`ifndef AUDIO_PWM_HOLD_LAST_EN
            m_cur = Mid;
`endif
          end
          exp_q.push_back(int'(m_cur));
        end
        if (!(tick && was_empty) && underrun_clr_i) m_under = 0;
        if (push) m_fifo.push_back(sample_data_i);
        m_cnt = tick ? 0 : m_cnt + 1;
      end
    end
  end

  // Monitor: measure pwm over cnt 0..Div of each period, seen 2..Per+1 cycles after a tick.
  bit hist[1024];
  int n = 0;
  int win_q[$];

  always @(negedge clk) begin
    int sum;
    n++;
    hist[n % 1024] = pwm_o;
    if (win_q.size() > 0 && n == win_q[0] + Per + 1) begin
      sum = 0;
      for (int k = 2; k <= Per + 1; k++) sum += int'(hist[(win_q[0] + k) % 1024]);
      void'(win_q.pop_front());
      if (exp_q.size() == 0) begin
        chk("period_expectation_present", 0, 1);
      end else begin
        chk("pwm_high_cycles", sum, exp_q.pop_front());
      end
    end
    if (sample_tick_o) win_q.push_back(n);
    if (!rstn || !en_i) begin
      win_q.delete();
      exp_q.delete();
    end
    chk("sample_ready_o", int'(sample_ready_o),
        int'(rstn && en_i && (m_fifo.size() < Depth)));
    chk("sample_tick_o", int'(sample_tick_o), int'(rstn && en_i && (m_cnt == Div)));
    chk("fifo_level_o", int'(fifo_level_o), m_fifo.size());
    chk("underrun_o", int'(underrun_o), int'(m_under));
    if (!rstn || !m_prev_en) chk("pwm_o_idle", int'(pwm_o), 0);
  end

  task automatic push_sample(input logic [7:0] d);
    bit acc;
    int guard;
    sample_valid_i = 1'b1;
    sample_data_i  = d;
    acc = 0;
    guard = 0;
    while (!acc && guard < 2000) begin
      @(negedge clk);
      acc = sample_ready_o;
      @(posedge clk);
      #1;
      guard++;
    end
    if (!acc) chk("push_accept_timeout", 0, 1);
    sample_valid_i = 1'b0;
  endtask

  task automatic idle(input int cyc);
    repeat (cyc) @(posedge clk);
    #1;
  endtask

  task automatic wait_tick;
    int guard = 0;
    do begin
      @(negedge clk);
      guard++;
    end while (!sample_tick_o && guard < 1000);
    if (!sample_tick_o) chk("tick_timeout", 0, 1);
  endtask

  task automatic clr_on_tick;
    wait_tick();
    underrun_clr_i = 1'b1;
    @(posedge clk);
    #1;
    underrun_clr_i = 1'b0;
  endtask

  initial begin
    rstn = 1'b0;
    en_i = 1'b1;
    sample_valid_i = 1'b0;
    sample_data_i = 8'h00;
    underrun_clr_i = 1'b0;
    idle(5);
    rstn = 1'b1;

    // Idle: first tick underruns, then a MIDSCALE period.
    idle(2 * Per + 10);

    // Two samples queued ahead of the next tick.
    push_sample(8'h40);
    push_sample(8'hC0);
    idle(3 * Per);

    // Burst of five: the fifth waits for a pop.
    for (int i = 0; i < 5; i++) push_sample(8'($urandom_range(1, 254)));
    idle(6 * Per);

    // Drain after 0x30, then clear alone and clear coinciding with an underrun tick.
    push_sample(8'h30);
    idle(2 * Per + 20);
    underrun_clr_i = 1'b1;
    idle(1);
    underrun_clr_i = 1'b0;
    clr_on_tick();
    idle(Per);

    // Extremes.
    push_sample(8'h00);
    push_sample(8'hFF);
    idle(3 * Per);

    // Disable mid-period with samples queued, then re-enable.
    wait_tick();
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) push_sample(8'($urandom_range(0, 255)));
    idle(95);
    en_i = 1'b0;
    idle(7);
    en_i = 1'b1;
    idle(2 * Per + 10);

    for (int it = 0; it < 40; it++) begin
      int r = int'($urandom_range(0, 9));
      if (r <= 5) begin
        push_sample(($urandom_range(0, 3) == 0) ? (($urandom_range(0, 1) == 0) ? 8'h00 : 8'hFF)
                                                : 8'($urandom_range(0, 255)));
      end else if (r == 6) begin
        idle(int'($urandom_range(1, 300)));
      end else if (r == 7) begin
        underrun_clr_i = 1'b1;
        idle(1);
        underrun_clr_i = 1'b0;
      end else if (r == 8) begin
        idle(int'($urandom_range(0, 259)));
        en_i = 1'b0;
        idle(int'($urandom_range(1, 20)));
        en_i = 1'b1;
      end else begin
        for (int i = 0; i < 5; i++) push_sample(8'($urandom_range(0, 255)));
      end
    end
    idle(3 * Per);

    // Async reset mid-period drops everything back to reset values.
    push_sample(8'h11);
    idle(50);
    rstn = 1'b0;
    idle(3);
    rstn = 1'b1;
    idle(2 * Per + 10);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
